// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator read-side datapath.
// Holds the BCD FSM state encoding and the double-dabble correction constants.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        SEND
    } bcd_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_CORR_THRESH = 4'd5;
    localparam bcd_digit_t BCD_CORR_ADD    = 4'd3;

endpackage

// File: rtl/dabble_nibble.sv
// Double-dabble correction for one BCD nibble: add 3 when the nibble is 5 or more,
// so that the following left shift carries correctly into the next decimal digit.
module dabble_nibble
    import calc_pkg::*;
(
    input  bcd_digit_t i_nibble,
    output bcd_digit_t o_nibble
);

    assign o_nibble = (i_nibble >= BCD_CORR_THRESH) ? bcd_digit_t'(i_nibble + BCD_CORR_ADD)
                                                    : i_nibble;

endmodule

// File: rtl/bcd_digit_reader.sv
// Converts a captured binary value to BCD (one double-dabble shift per cycle) and streams
// the digits MSD first over valid/ready. Define LEADING_ZERO_BLANK_EN to skip leading zeros.
module bcd_digit_reader
    import calc_pkg::*;
#(
    parameter int width  = 8,
    parameter int digits = 3
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    input  logic [width-1:0]           value_i,
    output logic                       busy_o,
    output bcd_digit_t                 digit_o,
    output logic                       digit_valid_o,
    input  logic                       digit_ready_i,
    output logic [$clog2(digits)-1:0]  digit_idx_o,
    output logic                       last_o
);

    localparam int IDX_W = $clog2(digits);
    localparam int CNT_W = $clog2(width + 1);
    localparam int BCD_W = 4 * digits;

    if ((10 ** digits) <= (2 ** width)) begin : g_bad_params
        $error("bcd_digit_reader: digits=%0d cannot represent width=%0d", digits, width);
    end

    bcd_state_t        r_state;
    bcd_state_t        w_next_state;
    logic [width-1:0]  r_bin;
    logic [BCD_W-1:0]  r_bcd;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;

    logic [BCD_W-1:0]       w_corr_bcd;
    logic [BCD_W+width-1:0] w_shift;
    logic [BCD_W-1:0]       w_shift_bcd;
    logic [width-1:0]       w_shift_bin;
    logic [IDX_W-1:0]       w_start_idx;
    bcd_digit_t             w_nib [digits];
    logic                   w_last_shift;
    logic                   w_xfer;

    for (genvar g = 0; g < digits; g++) begin : g_nib
        dabble_nibble u_dabble (
            .i_nibble (r_bcd[4*g +: 4]),
            .o_nibble (w_corr_bcd[4*g +: 4])
        );
        assign w_nib[g] = r_bcd[4*g +: 4];
    end

    // The top bit shifted out of the BCD field is always zero given the digits/width check.
    assign w_shift                    = {w_corr_bcd, r_bin} << 1;
    assign {w_shift_bcd, w_shift_bin} = w_shift;

    assign w_last_shift = (r_cnt == CNT_W'(1));
    assign w_xfer       = (r_state == SEND) && digit_ready_i;

`ifdef LEADING_ZERO_BLANK_EN
    bcd_digit_t w_shift_nib [digits];

    for (genvar g = 0; g < digits; g++) begin : g_shift_nib
        assign w_shift_nib[g] = w_shift_bcd[4*g +: 4];
    end

    // Start at the highest nonzero digit of the final shift result; zero sends a single digit.
    always_comb begin
        w_start_idx = '0;
        for (int k = 0; k < digits; k++) begin
            if (w_shift_nib[k] != '0) begin
                w_start_idx = IDX_W'(k);
            end
        end
    end
`else
    assign w_start_idx = IDX_W'(digits - 1);
`endif

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: default assignment first so that no path through the case leaves w_next_state
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start_i) w_next_state = CONVERT;
            CONVERT: if (w_last_shift) w_next_state = SEND;
            SEND:    if (w_xfer && (r_idx == '0)) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values, regardless of statement order.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_bin <= value_i;
                        r_bcd <= '0;
                        r_cnt <= CNT_W'(width);
                    end
                end
                CONVERT: begin
                    r_bcd <= w_shift_bcd;
                    r_bin <= w_shift_bin;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_last_shift) begin
                        r_idx <= w_start_idx;
                    end
                end
                SEND: begin
                    if (w_xfer && (r_idx != '0)) begin
                        r_idx <= r_idx - IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o        = (r_state != IDLE);
    assign digit_valid_o = (r_state == SEND);
    assign digit_o       = (r_state == SEND) ? w_nib[r_idx] : '0;
    assign digit_idx_o   = r_idx;
    assign last_o        = (r_state == SEND) && (r_idx == '0);

endmodule

// File: tb/tb_bcd_digit_reader.sv
// Directed bench for bcd_digit_reader: expected digits are pushed to a scoreboard at start
// and compared when each digit is transferred; handles LEADING_ZERO_BLANK_EN builds too.
module tb_bcd_digit_reader;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    typedef struct packed {
        logic [3:0] d;
        logic [1:0] idx;
        logic       last;
    } exp_t;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  value_i = '0;
    logic        busy_o;
    logic [3:0]  digit_o;
    logic        digit_valid_o;
    logic        digit_ready_i = 1'b0;
    logic [1:0]  digit_idx_o;
    logic        last_o;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_xfer   = 0;
    int   last_n   = 0;

    bcd_digit_reader #(.width(WIDTH), .digits(DIGITS)) dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .value_i       (value_i),
        .busy_o        (busy_o),
        .digit_o       (digit_o),
        .digit_valid_o (digit_valid_o),
        .digit_ready_i (digit_ready_i),
        .digit_idx_o   (digit_idx_o),
        .last_o        (last_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    // Decimal model: push the digits the DUT should send for v.
    task automatic push_expected(input int v);
        int dig [DIGITS];
        int first;
        exp_t e;
        for (int k = 0; k < DIGITS; k++) dig[k] = (v / (10 ** k)) % 10;
`ifdef LEADING_ZERO_BLANK_EN
        first = 0;
        for (int k = 0; k < DIGITS; k++) if (dig[k] != 0) first = k;
`else
        first = DIGITS - 1;
`endif
        last_n = first + 1;
        for (int i = first; i >= 0; i--) begin
            e.d    = 4'(dig[i]);
            e.idx  = 2'(i);
            e.last = (i == 0);
            sb.push_back(e);
        end
    endtask

    task automatic start(input logic [7:0] v);
        start_i = 1'b1;
        value_i = v;
        push_expected(int'(v));
        tick();
        start_i = 1'b0;
        value_i = 8'($urandom);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0 && !busy_o) break;
            tick();
        end
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_idle"}, busy_o, 1'b0);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (digit_valid_o) break;
            tick();
        end
        check({tag, "_valid"}, digit_valid_o, 1'b1);
    endtask

    // Scoreboard side: a transfer happens at the next rising edge when valid & ready.
    always @(negedge clock_i) begin
        if (reset_i && digit_valid_o) begin
            if (sb.size() == 0) begin
                check("unexpected_digit", 1, 0);
            end else if (digit_ready_i) begin
                exp_t e;
                e = sb.pop_front();
                n_xfer++;
                check("xfer_digit", digit_o, e.d);
                check("xfer_idx", digit_idx_o, e.idx);
                check("xfer_last", last_o, e.last);
            end else begin
                check("stall_digit", digit_o, sb[0].d);
                check("stall_idx", digit_idx_o, sb[0].idx);
            end
        end
    end

    initial begin
        int x0;

        // Reset state
        #12;
        check("rst_busy", busy_o, 1'b0);
        check("rst_valid", digit_valid_o, 1'b0);
        check("rst_digit", digit_o, 4'd0);
        check("rst_idx", digit_idx_o, 2'd0);
        check("rst_last", last_o, 1'b0);
        reset_i = 1'b1;
        tick();
        check("idle_after_rst", busy_o, 1'b0);

        // 255 with ready held high: latency and end-of-burst timing
        digit_ready_i = 1'b1;
        start(8'd255);
        check("255_busy", busy_o, 1'b1);
        repeat (7) tick();
        check("255_not_yet_valid", digit_valid_o, 1'b0);
        tick();
        check("255_first_valid", digit_valid_o, 1'b1);
        check("255_first_digit", digit_o, 4'd2);
        check("255_first_idx", digit_idx_o, 2'd2);
        check("255_first_last", last_o, 1'b0);
        repeat (3) tick();
        check("255_busy_low", busy_o, 1'b0);
        check("255_valid_low", digit_valid_o, 1'b0);
        check("255_sb_empty", sb.size(), 0);

        tick();
        start(8'd7);
        drain("v7");
        tick();
        start(8'd0);
        drain("v0");

        // 128 with four stall cycles on every digit
        tick();
        digit_ready_i = 1'b0;
        x0 = n_xfer;
        start(8'd128);
        wait_valid("v128");
        for (int d = 0; d < 3; d++) begin
            repeat (4) tick();
            digit_ready_i = 1'b1;
            tick();
            digit_ready_i = 1'b0;
        end
        check("v128_xfers", n_xfer - x0, 3);
        check("v128_idle", busy_o, 1'b0);
        check("v128_sb_empty", sb.size(), 0);

        // 42 with a competing start held through CONVERT, SEND and the final transfer
        tick();
        digit_ready_i = 1'b1;
        start(8'd42);
        start_i = 1'b1;
        value_i = 8'd99;
        repeat (WIDTH + last_n) tick();
        start_i = 1'b0;
        check("v42_sb_empty", sb.size(), 0);
        tick();
        check("v42_start_ignored", busy_o, 1'b0);

        // 200 aborted by reset while the second digit is presented
        tick();
        start(8'd200);
        repeat (9) tick();
        check("v200_second_idx", digit_idx_o, 2'd1);
        reset_i = 1'b0;
        #1;
        check("abort_busy", busy_o, 1'b0);
        check("abort_valid", digit_valid_o, 1'b0);
        check("abort_digit", digit_o, 4'd0);
        check("abort_idx", digit_idx_o, 2'd0);
        check("abort_last", last_o, 1'b0);
        sb.delete();
        repeat (2) tick();
        reset_i = 1'b1;
        repeat (3) tick();
        check("post_abort_idle", busy_o, 1'b0);
        check("post_abort_no_digit", digit_valid_o, 1'b0);
        start(8'd9);
        drain("v9");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
